// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared sizing defaults and FSM encodings for the UDP transmit path
package eth_tx_pkg;
    localparam int MAX_LEN_DEF = 1472;
    localparam int AW_DEF      = 11;
    typedef enum logic [1:0] {W_FILL, W_DROP, W_WAIT} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND} rd_state_t;
endpackage

// File: rtl/tx_pkt_ram.sv
// tx_pkt_ram: two-bank packet buffer, simple dual port with one-cycle registered read
module tx_pkt_ram #(
    parameter int AW = 11
) (
    input  logic          clk_200m,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**(AW+1)];
    always_ff @(posedge clk_200m) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk_200m) begin
        if (!rstn) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: packs an application byte stream into UDP payloads through a ping-pong buffer
module udp_tx_packetizer import eth_tx_pkg::*; #(
    parameter int MAX_LEN       = MAX_LEN_DEF,
    parameter int AW            = AW_DEF,
    parameter int FLUSH_TIMEOUT = 200000,
    parameter int TO_W          = 18
) (
    input  logic        clk_200m,
    input  logic        rstn,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tx_req,
    output logic [15:0] tx_len,
    input  logic        tx_ack,
    input  logic        tx_rd,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    output logic        ovf_pulse,
    output logic [15:0] pkt_cnt
);
    wr_state_t         wr_st_q, wr_st_d;
    rd_state_t         rd_st_q, rd_st_d;
    logic              run_q;
    logic [1:0]        full_q, full_d;
    logic [1:0][AW:0]  len_q, len_d;
    logic              wbank_q, wbank_d, rbank_q, rbank_d;
    logic [AW-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic              vld_q;
    logic              acc, fill, trunc, close, rd, done;
    always_comb begin
        acc   = s_valid && s_ready;
        fill  = wr_st_q == W_FILL;
        trunc = fill && acc && !s_last && {1'b0, wcnt_q} == (AW+1)'(MAX_LEN - 1);
        close = fill && ((acc && s_last) || trunc || (!acc && wcnt_q != '0 && to_q == TO_W'(FLUSH_TIMEOUT - 1)));
        rd    = rd_st_q == R_SEND && tx_rd;
        done  = rd && {1'b0, rcnt_q} + (AW+1)'(1) == len_q[rbank_q];
        wr_st_d   = wr_st_q;
        wcnt_d    = fill && acc ? wcnt_q + 1'b1 : wcnt_q;
        to_d      = fill && !acc && wcnt_q != '0 ? to_q + 1'b1 : '0;
        wbank_d   = wbank_q;
        full_d    = full_q;
        len_d     = len_q;
        rd_st_d   = rd_st_q;
        rcnt_d    = rd ? rcnt_q + 1'b1 : rcnt_q;
        rbank_d   = rbank_q;
        pkt_cnt_d = pkt_cnt_q;
        if (close) begin
            full_d[wbank_q] = 1'b1;
            len_d[wbank_q]  = {1'b0, wcnt_q} + (AW+1)'(acc);
            wcnt_d          = '0;
            to_d            = '0;
            wbank_d         = !wbank_q;
            wr_st_d         = trunc ? W_DROP : full_q[!wbank_q] ? W_WAIT : W_FILL;
        end
        if (wr_st_q == W_DROP && acc && s_last) wr_st_d = full_q[wbank_q] ? W_WAIT : W_FILL;
        if (wr_st_q == W_WAIT && !full_q[wbank_q]) wr_st_d = W_FILL;
        // a bank closing this cycle is offered immediately so tx_req follows the close by one cycle
        if (rd_st_q == R_IDLE && full_d[rbank_q]) rd_st_d = R_REQ;
        if (rd_st_q == R_REQ && tx_ack) rd_st_d = R_SEND;
        if (done) begin
            full_d[rbank_q] = 1'b0;
            pkt_cnt_d       = pkt_cnt_q + 1'b1;
            rbank_d         = !rbank_q;
            rcnt_d          = '0;
            rd_st_d         = R_IDLE;
        end
    end
    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            wr_st_q   <= W_FILL;
            rd_st_q   <= R_IDLE;
            run_q     <= 1'b0;
            full_q    <= '0;
            len_q     <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            to_q      <= '0;
            pkt_cnt_q <= '0;
            vld_q     <= 1'b0;
        end else begin
            wr_st_q   <= wr_st_d;
            rd_st_q   <= rd_st_d;
            run_q     <= 1'b1;
            full_q    <= full_d;
            len_q     <= len_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            to_q      <= to_d;
            pkt_cnt_q <= pkt_cnt_d;
            vld_q     <= rd;
        end
    end
    tx_pkt_ram #(.AW(AW)) u_ram (
        .clk_200m (clk_200m),
        .rstn     (rstn),
        .we       (fill && acc),
        .waddr    ({wbank_q, wcnt_q}),
        .wdata    (s_data),
        .re       (rd),
        .raddr    ({rbank_q, rcnt_q}),
        .rdata    (tx_data)
    );
    assign s_ready       = run_q && wr_st_q != W_WAIT;
    assign tx_req        = rd_st_q == R_REQ;
    assign tx_len        = 16'(len_q[rbank_q]);
    assign tx_data_valid = vld_q;
    assign ovf_pulse     = trunc;
    assign pkt_cnt       = pkt_cnt_q;
endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb_udp_tx_packetizer: randomized scenarios checked against a packet-level queue model
module tb_udp_tx_packetizer;
    localparam int MAX_LEN = 1472;
    localparam int TO      = 500;
    logic        clk_200m = 0, rstn = 0, s_valid = 0, s_last = 0, tx_ack = 0, tx_rd = 0;
    logic [7:0]  s_data = 0;
    logic        s_ready, tx_req, tx_data_valid, ovf_pulse;
    logic [15:0] tx_len, pkt_cnt;
    logic [7:0]  tx_data;
    int          checks = 0, errors = 0, ovf_seen = 0;
    int          exp_lens[$];
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_cnt = 0;

    udp_tx_packetizer #(.FLUSH_TIMEOUT(TO)) dut (
        .clk_200m(clk_200m), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .tx_req(tx_req), .tx_len(tx_len), .tx_ack(tx_ack), .tx_rd(tx_rd),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .ovf_pulse(ovf_pulse), .pkt_cnt(pkt_cnt)
    );

    always #5 clk_200m = ~clk_200m;

    always @(negedge clk_200m) begin
        #2;
        if (ovf_pulse === 1'b1) ovf_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] d, input logic last);
        int n = 0;
        s_valid = 1; s_data = d; s_last = last;
        while (s_ready !== 1'b1 && n < 5000) begin
            @(negedge clk_200m);
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL push_stall: s_ready=%b required 1 within 5000 cycles", s_ready);
        end
        @(negedge clk_200m);
        s_valid = 0; s_last = 0;
    endtask

    // model: a payload yields one packet of min(n, MAX_LEN) bytes, the excess is dropped
    task automatic send_pkt(input int n, input bit last, input bit ramp, input bit chk_req);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            if (i < MAX_LEN) exp_bytes.push_back(b);
            if (chk_req && i == n - 1) begin
                checks++;
                if (tx_req !== 1'b0) begin errors++; $display("FAIL req_early: tx_req=%b required 0", tx_req); end
            end
            push(b, last && i == n - 1);
        end
        exp_lens.push_back(n < MAX_LEN ? n : MAX_LEN);
        if (chk_req) begin
            checks++;
            if (tx_req !== 1'b1) begin errors++; $display("FAIL req_rise: tx_req=%b required 1", tx_req); end
        end
    endtask

    task automatic drain_one();
        int n = 0, len, i = 0;
        logic r;
        logic [7:0] b;
        while (tx_req !== 1'b1 && n < 5000) begin
            @(negedge clk_200m);
            n++;
        end
        checks++;
        if (tx_req !== 1'b1 || exp_lens.size() == 0) begin
            errors++;
            $display("FAIL drain_req: tx_req=%b required 1 (model packets %0d)", tx_req, exp_lens.size());
            return;
        end
        len = exp_lens.pop_front();
        checks++;
        if (tx_len !== 16'(len)) begin errors++; $display("FAIL tx_len: got %0d required %0d", tx_len, len); end
        tx_ack = 1;
        @(negedge clk_200m);
        tx_ack = 0;
        checks++;
        if (tx_req !== 1'b0) begin errors++; $display("FAIL req_after_ack: tx_req=%b required 0", tx_req); end
        while (i < len) begin
            r = $urandom_range(0, 3) != 0;
            tx_rd = r;
            @(negedge clk_200m);
            checks++;
            if (tx_data_valid !== r) begin errors++; $display("FAIL data_valid: got %b required %b at byte %0d", tx_data_valid, r, i); end
            if (r) begin
                b = exp_bytes.pop_front();
                checks++;
                if (tx_data !== b) begin errors++; $display("FAIL tx_data: got %h required %h at byte %0d", tx_data, b, i); end
                i++;
            end
        end
        tx_rd = 0;
        exp_cnt++;
        checks++;
        if (pkt_cnt !== exp_cnt) begin errors++; $display("FAIL pkt_cnt: got %0d required %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(negedge clk_200m);
        checks++;
        if ({s_ready, tx_req, tx_data_valid, ovf_pulse} !== 4'b0000 || tx_len !== 16'd0 || tx_data !== 8'd0 || pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_vals: ready=%b req=%b vld=%b ovf=%b len=%0d data=%h cnt=%0d required all 0",
                     s_ready, tx_req, tx_data_valid, ovf_pulse, tx_len, tx_data, pkt_cnt);
        end
        rstn = 1;
        @(negedge clk_200m);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_basic();
        send_pkt(64, 1, 1, 1);
        drain_one();
        tx_rd = 1;
        @(negedge clk_200m);
        tx_rd = 0;
        checks++;
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rd_ignored: tx_data_valid=%b required 0", tx_data_valid); end
    endtask

    task automatic test_overflow();
        int ovf0 = ovf_seen;
        send_pkt(1473, 1, 0, 0);
        send_pkt(20, 1, 0, 0);
        drain_one();
        drain_one();
        checks++;
        if (ovf_seen - ovf0 !== 1) begin errors++; $display("FAIL ovf_count: got %0d pulses required 1", ovf_seen - ovf0); end
    endtask

    task automatic test_timeout();
        send_pkt(10, 0, 0, 0);
        repeat (TO - 1) @(negedge clk_200m);
        checks++;
        if (tx_req !== 1'b0) begin errors++; $display("FAIL timeout_early: tx_req=%b required 0", tx_req); end
        @(negedge clk_200m);
        checks++;
        if (tx_req !== 1'b1) begin errors++; $display("FAIL timeout_close: tx_req=%b required 1", tx_req); end
        drain_one();
    endtask

    task automatic test_back_to_back();
        send_pkt(100, 1, 0, 0);
        send_pkt(100, 1, 0, 0);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL ready_both_full: s_ready=%b required 0", s_ready); end
        fork
            send_pkt(100, 1, 0, 0);
            drain_one();
        join
        drain_one();
        drain_one();
    endtask

    task automatic test_single();
        exp_bytes.push_back(8'hA5);
        exp_lens.push_back(1);
        checks++;
        if (tx_req !== 1'b0) begin errors++; $display("FAIL single_early: tx_req=%b required 0", tx_req); end
        push(8'hA5, 1);
        checks++;
        if (tx_req !== 1'b1) begin errors++; $display("FAIL single_req: tx_req=%b required 1", tx_req); end
        drain_one();
    endtask

    task automatic test_reset_mid();
        send_pkt(40, 1, 0, 0);
        send_pkt(30, 0, 0, 0);
        tx_ack = 1;
        @(negedge clk_200m);
        tx_ack = 0;
        tx_rd = 1;
        repeat (5) @(negedge clk_200m);
        rstn = 0;
        repeat (2) @(negedge clk_200m);
        checks++;
        if ({tx_req, tx_data_valid, s_ready} !== 3'b000 || tx_data !== 8'd0 || pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: req=%b vld=%b ready=%b data=%h cnt=%0d required all 0", tx_req, tx_data_valid, s_ready, tx_data, pkt_cnt);
        end
        tx_rd = 0;
        rstn = 1;
        @(negedge clk_200m);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_mid_reset: s_ready=%b required 1", s_ready); end
        exp_lens.delete();
        exp_bytes.delete();
        exp_cnt = 0;
        send_pkt(8, 1, 0, 1);
        drain_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_single();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
